mvb_frame_sequencer: RTL and testbench
======================================

// Module: mvb_frame_sequencer
// PURPOSE
//  Sits between the Manchester/delimiter decoder and the bitwise CRC checker on the MVB receive path.
//  Counts decoded bits of one frame and splits them into check groups (<=64 data bits + 8 check bits).
//  Drives the checker's crc_ready/crc_read/data strobes, one cycle per bit.
//  Assembles each group's data bits into a parallel word and reports frame completion or truncation.
// PARAMETERS
//  MAX_GROUPS  4   max 64-bit check groups per frame (256 data bits); sizes word_idx
//  CHK_BITS    8   check bits per group
// PORTS
//  clk_3M      in   1   3 MHz system clock, single domain
//  rst         in   1   synchronous reset, active-high
//  frame_start in   1   1-cycle pulse: start delimiter decoded, frame begins
//  f_code      in   3   length code, sampled with frame_start: 0=16,1=32,2=64,3=128,4=256 data bits; 5-7 invalid
//  bit_valid   in   1   1-cycle strobe per decoded bit (>=1 idle cycle between strobes at 1.5 Mbit/s)
//  bit_data    in   1   decoded bit, valid with bit_valid, MSB first
//  frame_end   in   1   1-cycle pulse: end delimiter / line violation seen
//  crc_ready   out  1   1-cycle pulse per bit forwarded to CRC checker
//  crc_read    out  1   high with crc_ready while forwarding check bits
//  crc_data    out  1   bit forwarded to CRC checker, valid with crc_ready
//  data_word   out  64  data bits of last completed group, right-aligned, MSB = first received
//  word_valid  out  1   1-cycle pulse: data_word updated
//  word_idx    out  2   group number of data_word (0..MAX_GROUPS-1)
//  busy        out  1   frame in progress (state != IDLE)
//  frame_done  out  1   1-cycle pulse: all groups of frame received
//  frame_err   out  1   1-cycle pulse: frame aborted; cause in err_code
//  err_code    out  2   0=none,1=truncated (frame_end early),2=restart (frame_start mid-frame),3=bad f_code
// BEHAVIOUR
//  Reset: all outputs 0, data_word=0, state IDLE, counters 0. Reset mid-frame drops frame silently (no frame_err).
//  FSM: IDLE -> DATA on frame_start with valid f_code; bad f_code -> frame_err, err_code=3, stay IDLE.
//   DATA: each bit_valid shifts bit into data shift reg, bit_cnt++; after grp_len bits -> CHECK, bit_cnt=0.
//   CHECK: each bit_valid forwarded with crc_read=1; after CHK_BITS bits -> word_valid, then
//          DATA if groups remain, else DONE.
//   DONE: frame_done pulse once on entry; further bits ignored; -> IDLE on frame_end or frame_start
//         (frame_start here starts new frame directly, no error).
//  grp_len = min(total,64): 16/32/64 for codes 0-2, 64 for codes 3-4; groups = total/64 rounded up (1,1,1,2,4).
//  Latency: crc_ready/crc_read/crc_data registered, 1 cycle after bit_valid. word_valid/frame_done asserted
//   1 cycle after last check bit's bit_valid (same cycle as its crc_ready).
//  data_word: 16/32-bit groups right-aligned, upper bits 0; held until next word_valid.
//  frame_end in DATA/CHECK -> frame_err, err_code=1, IDLE; partial word not published.
//  frame_start in DATA/CHECK -> frame_err, err_code=2, restart counters, sample new f_code, enter DATA.
//  Simultaneous bit_valid and frame_end: bit processed first; if it completes frame -> frame_done only, no error.
//  Simultaneous frame_start and bit_valid: frame_start wins, bit dropped.
//  err_code held until next frame_err or frame_start; cleared by rst.
//  bit_valid in IDLE ignored, no crc_ready.
// STRUCTURE
//  Shared package mvb_pkg: state enum (IDLE,DATA,CHECK,DONE), f_code constants, err_code constants,
//   grp_len/grp_count decode functions.
//  No sub-module; bit_cnt (7b), grp_cnt (2b), 64b shift reg and FSM are all local.
// TESTING
//  f_code=0, 16 bits 0xA5C3 + 8 check bits -> 24 crc_ready, last 8 with crc_read; data_word=0x..A5C3, word_idx=0, frame_done.
//  f_code=3, 144 bits -> two word_valid (idx 0,1), crc_read pulses 8+8, frame_done once after bit 144.
//  f_code=2, frame_end after 40 bits -> frame_err, err_code=1, no word_valid, busy=0 next cycle.
//  frame_start after 20 bits of f_code=1 frame -> frame_err, err_code=2, new frame completes normally.
//  f_code=6 -> frame_err, err_code=3, busy stays 0, bits ignored.
//  rst pulse mid-CHECK -> all outputs 0 next cycle, no frame_err; next frame_start works.

Source files
------------

// File: rtl/mvb_pkg.sv
// Shared types, constants and length-code decode for the MVB frame sequencer.
package mvb_pkg;

    localparam int MAX_GROUPS = 4;
    localparam int CHK_BITS   = 8;
    localparam int GRP_W      = $clog2(MAX_GROUPS);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DATA  = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // Length codes: data bits per frame
    localparam logic [2:0] FC_16  = 3'd0;
    localparam logic [2:0] FC_32  = 3'd1;
    localparam logic [2:0] FC_64  = 3'd2;
    localparam logic [2:0] FC_128 = 3'd3;
    localparam logic [2:0] FC_256 = 3'd4;

    // Abort causes reported on err_code
    localparam logic [1:0] ERR_NONE      = 2'd0;
    localparam logic [1:0] ERR_TRUNC     = 2'd1;
    localparam logic [1:0] ERR_RESTART   = 2'd2;
    localparam logic [1:0] ERR_BAD_FCODE = 2'd3;

    function automatic logic fcode_ok(input logic [2:0] fc);
        return fc <= FC_256;
    endfunction

    // Data bits per check group: whole frame for short codes, 64 otherwise
    function automatic logic [6:0] grp_len(input logic [2:0] fc);
        case (fc)
            FC_16:   return 7'd16;
            FC_32:   return 7'd32;
            default: return 7'd64;
        endcase
    endfunction

    // Index of the last group of the frame (group count minus one)
    function automatic logic [GRP_W-1:0] grp_last(input logic [2:0] fc);
        case (fc)
            FC_128:  return GRP_W'(1);
            FC_256:  return GRP_W'(3);
            default: return GRP_W'(0);
        endcase
    endfunction

endpackage

// File: rtl/mvb_frame_sequencer_if.sv
// Bit-stream and CRC-strobe bundle between decoder, sequencer and CRC checker.
// Strobe semantics: there is no back-pressure on this path. bit_valid,
// frame_start and frame_end are single-cycle qualifiers from the decoder;
// crc_ready, word_valid, frame_done and frame_err are single-cycle
// qualifiers from the sequencer, and their payloads (crc_read/crc_data,
// data_word/word_idx, err_code) are only meaningful in the cycle the
// qualifier is high (err_code and data_word additionally hold afterwards).
interface mvb_frame_sequencer_if;
    import mvb_pkg::*;

    logic             frame_start;
    logic [2:0]       f_code;
    logic             bit_valid;
    logic             bit_data;
    logic             frame_end;

    logic             crc_ready;
    logic             crc_read;
    logic             crc_data;
    logic [63:0]      data_word;
    logic             word_valid;
    logic [GRP_W-1:0] word_idx;
    logic             busy;
    logic             frame_done;
    logic             frame_err;
    logic [1:0]       err_code;
    state_e           state_dbg;

    modport master (
        output frame_start, f_code, bit_valid, bit_data, frame_end,
        input  crc_ready, crc_read, crc_data, data_word, word_valid, word_idx,
               busy, frame_done, frame_err, err_code, state_dbg
    );

    modport slave (
        input  frame_start, f_code, bit_valid, bit_data, frame_end,
        output crc_ready, crc_read, crc_data, data_word, word_valid, word_idx,
               busy, frame_done, frame_err, err_code, state_dbg
    );
endinterface

// File: rtl/mvb_frame_sequencer.sv
// Splits a decoded MVB frame into check groups, strobes each bit to the CRC
// checker and publishes the data bits of every completed group.
module mvb_frame_sequencer
    import mvb_pkg::*;
(
    input  logic                  clk_3M,
    input  logic                  rst,
    mvb_frame_sequencer_if.slave  bus
);

    state_e           state_q, state_d;
    logic [6:0]       bit_cnt_q, bit_cnt_d, bit_cnt_inc;
    logic [GRP_W-1:0] grp_cnt_q, grp_cnt_d;
    logic [GRP_W-1:0] grp_last_q, grp_last_d;
    logic [6:0]       grp_len_q, grp_len_d;
    logic [63:0]      shift_q, shift_d;
    logic [63:0]      data_word_q, data_word_d;
    logic [GRP_W-1:0] word_idx_q, word_idx_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             crc_ready_q, crc_ready_d;
    logic             crc_read_q, crc_read_d;
    logic             crc_data_q, crc_data_d;
    logic             word_valid_q, word_valid_d;
    logic             frame_done_q, frame_done_d;
    logic             frame_err_q, frame_err_d;

    // Next-state and strobe decode; frame_start overrides any bit in the same cycle
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        bit_cnt_inc  = bit_cnt_q + 7'd1;
        grp_cnt_d    = grp_cnt_q;
        grp_last_d   = grp_last_q;
        grp_len_d    = grp_len_q;
        shift_d      = shift_q;
        data_word_d  = data_word_q;
        word_idx_d   = word_idx_q;
        err_code_d   = err_code_q;
        crc_ready_d  = 1'b0;
        crc_read_d   = 1'b0;
        crc_data_d   = 1'b0;
        word_valid_d = 1'b0;
        frame_done_d = 1'b0;
        frame_err_d  = 1'b0;

        if (bus.frame_start) begin
            if (!fcode_ok(bus.f_code)) begin
                // A frame that cannot be sized is rejected outright
                frame_err_d = 1'b1;
                err_code_d  = ERR_BAD_FCODE;
                state_d     = ST_IDLE;
            end else begin
                if (state_q == ST_DATA || state_q == ST_CHECK) begin
                    frame_err_d = 1'b1;
                    err_code_d  = ERR_RESTART;
                end else begin
                    err_code_d  = ERR_NONE;
                end
                state_d    = ST_DATA;
                bit_cnt_d  = '0;
                grp_cnt_d  = '0;
                grp_len_d  = grp_len(bus.f_code);
                grp_last_d = grp_last(bus.f_code);
                shift_d    = '0;
            end
        end else begin
            case (state_q)
                ST_DATA: begin
                    if (bus.bit_valid) begin
                        crc_ready_d = 1'b1;
                        crc_data_d  = bus.bit_data;
                        shift_d     = {shift_q[62:0], bus.bit_data};
                        bit_cnt_d   = bit_cnt_inc;
                        if (bit_cnt_inc == grp_len_q) begin
                            state_d   = ST_CHECK;
                            bit_cnt_d = '0;
                        end
                    end
                    // A data bit can never finish the frame, so an end here is always early
                    if (bus.frame_end) begin
                        frame_err_d = 1'b1;
                        err_code_d  = ERR_TRUNC;
                        state_d     = ST_IDLE;
                    end
                end
                ST_CHECK: begin
                    if (bus.bit_valid) begin
                        crc_ready_d = 1'b1;
                        crc_read_d  = 1'b1;
                        crc_data_d  = bus.bit_data;
                        bit_cnt_d   = bit_cnt_inc;
                        if (bit_cnt_inc == 7'(CHK_BITS)) begin
                            // Shift reg was cleared at group start, so short groups are right-aligned
                            word_valid_d = 1'b1;
                            data_word_d  = shift_q;
                            word_idx_d   = grp_cnt_q;
                            bit_cnt_d    = '0;
                            shift_d      = '0;
                            if (grp_cnt_q == grp_last_q) begin
                                state_d      = ST_DONE;
                                frame_done_d = 1'b1;
                            end else begin
                                state_d   = ST_DATA;
                                grp_cnt_d = grp_cnt_q + GRP_W'(1);
                            end
                        end
                    end
                    if (bus.frame_end) begin
                        if (frame_done_d) begin
                            // End delimiter arrived with the last check bit: frame is good
                            state_d = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            err_code_d  = ERR_TRUNC;
                            state_d     = ST_IDLE;
                        end
                    end
                end
                ST_DONE: begin
                    if (bus.frame_end) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // State and output registers; reset drops any frame without reporting it
    always_ff @(posedge clk_3M) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= '0;
            grp_cnt_q    <= '0;
            grp_last_q   <= '0;
            grp_len_q    <= '0;
            shift_q      <= '0;
            data_word_q  <= '0;
            word_idx_q   <= '0;
            err_code_q   <= ERR_NONE;
            crc_ready_q  <= 1'b0;
            crc_read_q   <= 1'b0;
            crc_data_q   <= 1'b0;
            word_valid_q <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            bit_cnt_q    <= bit_cnt_d;
            grp_cnt_q    <= grp_cnt_d;
            grp_last_q   <= grp_last_d;
            grp_len_q    <= grp_len_d;
            shift_q      <= shift_d;
            data_word_q  <= data_word_d;
            word_idx_q   <= word_idx_d;
            err_code_q   <= err_code_d;
            crc_ready_q  <= crc_ready_d;
            crc_read_q   <= crc_read_d;
            crc_data_q   <= crc_data_d;
            word_valid_q <= word_valid_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    assign bus.crc_ready  = crc_ready_q;
    assign bus.crc_read   = crc_read_q;
    assign bus.crc_data   = crc_data_q;
    assign bus.data_word  = data_word_q;
    assign bus.word_valid = word_valid_q;
    assign bus.word_idx   = word_idx_q;
    assign bus.busy       = (state_q != ST_IDLE);
    assign bus.frame_done = frame_done_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.err_code   = err_code_q;
    assign bus.state_dbg  = state_q;

endmodule

// File: tb/tb_mvb_frame_sequencer.sv
// Bench for mvb_frame_sequencer: table vectors, directed corner sequences and
// randomized frames checked against a bit-position reference model.
module tb_mvb_frame_sequencer;
    import mvb_pkg::*;

    localparam int OW = 75;

    // ---------------- clock / reset ----------------
    logic clk_3M = 1'b0;
    logic rst;
    always #10 clk_3M = ~clk_3M;

    mvb_frame_sequencer_if bus();

    mvb_frame_sequencer dut (
        .clk_3M (clk_3M),
        .rst    (rst),
        .bus    (bus)
    );

    // ---------------- scoreboard ----------------
    logic [OW-1:0] exp_q[$];
    int n_total = 0;
    int n_bad   = 0;

    // observed-event counters for directed sequences
    int          n_cr, n_crd, n_wv, n_fd, n_ferr;
    logic [63:0] last_word;
    logic [1:0]  last_idx;

    // reference model: frame tracked as a bit position, not as states
    bit          m_active, m_done;
    logic [2:0]  m_fc;
    int          m_pos;
    bit          m_bits[$];
    logic [63:0] m_word;
    logic [1:0]  m_idx;
    logic [1:0]  m_err;

    task automatic check(input string name, input logic [OW-1:0] got, input logic [OW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    function automatic int frame_bits(input logic [2:0] fc);
        return 16 << fc;
    endfunction

    function automatic void model_step(input logic r, input logic fs, input logic [2:0] fc,
                                       input logic bv, input logic bd, input logic fe);
        bit cr = 0, crd = 0, cd = 0, wv = 0, fd = 0, fer = 0;
        int tot, glen, ngrp, per, off, g;
        if (r) begin
            m_active = 0; m_done = 0; m_pos = 0; m_bits.delete();
            m_word = '0; m_idx = '0; m_err = '0;
        end else if (fs) begin
            if (fc > 3'd4) begin
                fer = 1; m_err = 2'd3; m_active = 0; m_done = 0;
            end else begin
                if (m_active) begin fer = 1; m_err = 2'd2; end
                else m_err = 2'd0;
                m_active = 1; m_done = 0; m_fc = fc; m_pos = 0; m_bits.delete();
            end
        end else begin
            if (m_active && bv) begin
                tot  = frame_bits(m_fc);
                glen = (tot < 64) ? tot : 64;
                ngrp = (tot + 63) / 64;
                per  = glen + CHK_BITS;
                off  = m_pos % per;
                g    = m_pos / per;
                cr   = 1;
                cd   = bd;
                crd  = (off >= glen);
                if (off < glen) m_bits.push_back(bd);
                if (off == per - 1) begin
                    wv = 1;
                    m_word = '0;
                    foreach (m_bits[i]) m_word = m_word * 2 + 64'(m_bits[i]);
                    m_bits.delete();
                    m_idx = 2'(g);
                    if (g == ngrp - 1) begin
                        fd = 1; m_active = 0; m_done = 1;
                    end
                end
                m_pos++;
            end
            if (fe) begin
                if (m_active) begin fer = 1; m_err = 2'd1; m_active = 0; end
                else m_done = 0;
            end
        end
        exp_q.push_back({cr, crd, cd, wv, m_idx, (m_active | m_done), fd, fer, m_err, m_word});
    endfunction

    function automatic logic [OW-1:0] sample_out();
        return {bus.crc_ready, bus.crc_read, bus.crc_data, bus.word_valid, bus.word_idx,
                bus.busy, bus.frame_done, bus.frame_err, bus.err_code, bus.data_word};
    endfunction

    // ---------------- driver tasks ----------------
    // Called at a negedge: drive, let one posedge pass, sample at the next negedge.
    task automatic step(input logic r, input logic fs, input logic [2:0] fc,
                        input logic bv, input logic bd, input logic fe);
        logic [OW-1:0] got;
        rst             = r;
        bus.frame_start = fs;
        bus.f_code      = fc;
        bus.bit_valid   = bv;
        bus.bit_data    = bd;
        bus.frame_end   = fe;
        model_step(r, fs, fc, bv, bd, fe);
        @(posedge clk_3M);
        @(negedge clk_3M);
        got = sample_out();
        check("outputs", got, exp_q.pop_front());
        if (bus.crc_ready)  n_cr++;
        if (bus.crc_read)   n_crd++;
        if (bus.frame_done) n_fd++;
        if (bus.frame_err)  n_ferr++;
        if (bus.word_valid) begin
            n_wv++;
            last_word = bus.data_word;
            last_idx  = bus.word_idx;
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 3'd0, 0, 0, 0);
    endtask

    task automatic send_bit(input logic bd);
        step(0, 0, 3'd0, 1, bd, 0);
        idle($urandom_range(1, 2));
    endtask

    task automatic clr();
        n_cr = 0; n_crd = 0; n_wv = 0; n_fd = 0; n_ferr = 0;
        last_word = '0; last_idx = '0;
    endtask

    // ---------------- table vectors ----------------
    typedef struct {
        logic       r, fs;
        logic [2:0] fc;
        logic       bv, bd, fe;
        logic       e_busy, e_cr, e_ferr;
        logic [1:0] e_code;
    } vec_t;

    vec_t tbl[10];

    initial begin
        logic [15:0] pat;
        logic [7:0]  chk;
        logic [2:0]  fc;
        int          mode, len, cut, tot;

        tbl[0] = '{1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd0}; // reset
        tbl[1] = '{0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 2'd0}; // bit in idle ignored
        tbl[2] = '{0, 1, 3'd6, 1, 0, 0, 0, 0, 1, 2'd3}; // bad f_code
        tbl[3] = '{0, 0, 3'd0, 1, 1, 0, 0, 0, 0, 2'd3}; // code held, bit ignored
        tbl[4] = '{0, 1, 3'd0, 0, 0, 0, 1, 0, 0, 2'd0}; // good start clears code
        tbl[5] = '{0, 0, 3'd0, 1, 1, 0, 1, 1, 0, 2'd0}; // first data bit forwarded
        tbl[6] = '{0, 0, 3'd0, 0, 0, 0, 1, 0, 0, 2'd0};
        tbl[7] = '{0, 0, 3'd0, 0, 0, 1, 0, 0, 1, 2'd1}; // early end
        tbl[8] = '{0, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd1}; // code held
        tbl[9] = '{1, 0, 3'd0, 0, 0, 0, 0, 0, 0, 2'd0}; // reset clears code

        rst = 1'b1;
        bus.frame_start = 0; bus.f_code = 0; bus.bit_valid = 0;
        bus.bit_data = 0; bus.frame_end = 0;
        clr();
        @(negedge clk_3M);
        step(1, 0, 3'd0, 0, 0, 0);
        check("reset_state", OW'(sample_out()), OW'(0));

        for (int i = 0; i < 10; i++) begin
            step(tbl[i].r, tbl[i].fs, tbl[i].fc, tbl[i].bv, tbl[i].bd, tbl[i].fe);
            check($sformatf("tbl_%0d", i),
                  OW'({bus.busy, bus.crc_ready, bus.frame_err, bus.err_code}),
                  OW'({tbl[i].e_busy, tbl[i].e_cr, tbl[i].e_ferr, tbl[i].e_code}));
        end

        // 16-bit frame 0xA5C3 plus 8 check bits
        clr();
        pat = 16'hA5C3; chk = 8'h3C;
        step(0, 1, 3'd0, 0, 0, 0);
        for (int i = 15; i >= 0; i--) send_bit(pat[i]);
        for (int i = 7; i >= 0; i--) send_bit(chk[i]);
        check("f16_crc_ready_cnt", OW'(n_cr), OW'(24));
        check("f16_crc_read_cnt", OW'(n_crd), OW'(8));
        check("f16_word", OW'(last_word), OW'(64'hA5C3));
        check("f16_idx", OW'(last_idx), OW'(0));
        check("f16_done_cnt", OW'(n_fd), OW'(1));
        step(0, 0, 3'd0, 0, 0, 1);
        check("f16_idle_after_end", OW'(bus.busy), OW'(0));

        // 128-bit frame: two groups
        clr();
        step(0, 1, 3'd3, 0, 0, 0);
        for (int i = 0; i < 144; i++) send_bit(1'($urandom_range(0, 1)));
        check("f128_word_cnt", OW'(n_wv), OW'(2));
        check("f128_crc_read_cnt", OW'(n_crd), OW'(16));
        check("f128_done_cnt", OW'(n_fd), OW'(1));
        check("f128_last_idx", OW'(last_idx), OW'(1));
        step(0, 0, 3'd0, 0, 0, 1);

        // 64-bit frame truncated after 40 bits
        clr();
        step(0, 1, 3'd2, 0, 0, 0);
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        step(0, 0, 3'd0, 0, 0, 1);
        check("trunc_err_cnt", OW'(n_ferr), OW'(1));
        check("trunc_code", OW'(bus.err_code), OW'(1));
        check("trunc_no_word", OW'(n_wv), OW'(0));
        check("trunc_busy", OW'(bus.busy), OW'(0));

        // restart after 20 bits of a 32-bit frame
        clr();
        step(0, 1, 3'd1, 0, 0, 0);
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
        step(0, 1, 3'd1, 1, 1, 0);
        check("restart_code", OW'(bus.err_code), OW'(2));
        for (int i = 0; i < 40; i++) send_bit(1'($urandom_range(0, 1)));
        check("restart_err_cnt", OW'(n_ferr), OW'(1));
        check("restart_done_cnt", OW'(n_fd), OW'(1));
        check("restart_word_cnt", OW'(n_wv), OW'(1));
        step(0, 0, 3'd0, 0, 0, 1);

        // bad f_code then bits
        clr();
        step(0, 1, 3'd6, 0, 0, 0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        check("badfc_no_crc", OW'(n_cr), OW'(0));
        check("badfc_busy", OW'(bus.busy), OW'(0));
        check("badfc_code", OW'(bus.err_code), OW'(3));

        // reset in the middle of the check bits
        clr();
        step(0, 1, 3'd0, 0, 0, 0);
        for (int i = 0; i < 19; i++) send_bit(1'($urandom_range(0, 1)));
        step(1, 0, 3'd0, 0, 0, 0);
        check("rst_mid_outputs", OW'(sample_out()), OW'(0));
        check("rst_mid_no_err", OW'(n_ferr), OW'(0));
        clr();
        step(0, 1, 3'd0, 0, 0, 0);
        for (int i = 0; i < 24; i++) send_bit(1'($urandom_range(0, 1)));
        check("rst_then_done", OW'(n_fd), OW'(1));
        step(0, 0, 3'd0, 0, 0, 1);

        // randomized frames against the model
        for (int f = 0; f < 30; f++) begin
            fc   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
            mode = $urandom_range(0, 9);
            step(0, 1, fc, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0);
            if (fc <= 3'd4) begin
                tot = frame_bits(fc);
                len = tot + ((tot + 63) / 64) * CHK_BITS;
            end else begin
                len = 4;
            end
            cut = (mode >= 7) ? $urandom_range(1, len - 1) : len;
            for (int i = 0; i < cut; i++) begin
                step(0, 0, 3'd0, 1, 1'($urandom_range(0, 1)), (mode == 1 && i == cut - 1));
                idle($urandom_range(1, 2));
            end
            case (mode)
                1, 8: ;
                7: step(0, 0, 3'd0, 0, 0, 1);
                9: step(1, 0, 3'd0, 0, 0, 0);
                default: begin
                    for (int i = 0; i < mode % 3; i++) send_bit(1'($urandom_range(0, 1)));
                    if (mode != 2) step(0, 0, 3'd0, 0, 0, 1);
                end
            endcase
        end
        idle(3);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
